// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver, the RX byte FIFO and the CPU read path.
// The slave modport is the FIFO side; the master modport is the UART/CPU side.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] uart_data;
  logic             uart_valid;
  logic             uart_ready;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             underflow;
  logic             clr_underflow;

  modport slave (
    input  uart_data, uart_valid, rd_en, clr_underflow,
    output uart_ready, rd_data, empty, full, count, underflow
  );

  modport master (
    output uart_data, uart_valid, rd_en, clr_underflow,
    input  uart_ready, rd_data, empty, full, count, underflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive byte FIFO between the UART receiver and the CPU UART read port.
// Reports count/empty/full and keeps a sticky underflow flag for firmware debug.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             underflow_q, underflow_d;

  logic empty_w;
  logic full_w;
  logic push;
  logic pop;

  // Status is decoded from registered count only, so ready never depends on this cycle's inputs.
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));
  assign push    = bus.uart_valid && !full_w;
  assign pop     = bus.rd_en && !empty_w;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    // A fresh underflow in the same cycle as a clear must remain visible.
    if (bus.clr_underflow)        underflow_d = 1'b0;
    if (bus.rd_en && empty_w)     underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is left uninitialised; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.uart_data;
  end

  assign bus.uart_ready = !full_w;
  assign bus.empty      = empty_w;
  assign bus.full       = full_w;
  assign bus.count      = count_q;
  assign bus.underflow  = underflow_q;
  assign bus.rd_data    = empty_w ? '0 : mem_q[rd_ptr_q];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, hand-written corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic clk;
  logic rst;

  uart_rx_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q[$];
  logic       model_uf;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       c;
    int         e_count;
    logic [7:0] e_data;
    logic       e_uf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] exp_data;
    int         n;
    n        = model_q.size();
    exp_data = (n > 0) ? model_q[0] : 8'h00;
    check({tag, ".count"},      32'(bus.count),      32'(n));
    check({tag, ".empty"},      32'(bus.empty),      32'(n == 0));
    check({tag, ".full"},       32'(bus.full),       32'(n == DEPTH));
    check({tag, ".uart_ready"}, 32'(bus.uart_ready), 32'(n != DEPTH));
    check({tag, ".rd_data"},    32'(bus.rd_data),    32'(exp_data));
    check({tag, ".underflow"},  32'(bus.underflow),  32'(model_uf));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".count"},      32'(bus.count),      32'd0);
    check({tag, ".empty"},      32'(bus.empty),      32'd1);
    check({tag, ".full"},       32'(bus.full),       32'd0);
    check({tag, ".uart_ready"}, 32'(bus.uart_ready), 32'd1);
    check({tag, ".rd_data"},    32'(bus.rd_data),    32'h00);
    check({tag, ".underflow"},  32'(bus.underflow),  32'd0);
  endtask

  // One clock: drive inputs, advance the model by the FIFO rules, then compare after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c,
                      input string tag);
    int  n;
    bit  do_push;
    bit  do_pop;
    bus.uart_valid    = v;
    bus.uart_data     = d;
    bus.rd_en         = r;
    bus.clr_underflow = c;
    n       = model_q.size();
    do_push = v && (n < DEPTH);
    do_pop  = r && (n > 0);
    if (c)          model_uf = 1'b0;
    if (r && n == 0) model_uf = 1'b1;
    if (do_pop)  void'(model_q.pop_front());
    if (do_push) model_q.push_back(d);
    @(posedge clk);
    #1;
    bus.uart_valid    = 1'b0;
    bus.rd_en         = 1'b0;
    bus.clr_underflow = 1'b0;
    check_model(tag);
  endtask

  initial begin
    logic [7:0] rd;
    bit         ph;

    bus.uart_valid    = 1'b0;
    bus.uart_data     = 8'h00;
    bus.rd_en         = 1'b0;
    bus.clr_underflow = 1'b0;
    model_uf          = 1'b0;

    // Reset asserted before the first clock edge: outputs must already be at reset values.
    rst = 1'b1;
    #3;
    check_reset_values("reset_async");
    @(posedge clk);
    #1;
    rst = 1'b0;

    vecs[0]  = '{1'b1, 8'h7a, 1'b0, 1'b0, 1, 8'h7a, 1'b0};
    vecs[1]  = '{1'b1, 8'h80, 1'b0, 1'b0, 2, 8'h7a, 1'b0};
    vecs[2]  = '{1'b1, 8'h55, 1'b0, 1'b0, 3, 8'h7a, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 8'h80, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'h55, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 8'h00, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 8'h00, 1'b0};
    vecs[9]  = '{1'b1, 8'haa, 1'b1, 1'b0, 1, 8'haa, 1'b1};
    vecs[10] = '{1'b1, 8'hbb, 1'b1, 1'b0, 1, 8'hbb, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 8'hbb, 1'b0};

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_count", i), 32'(bus.count),     32'(vecs[i].e_count));
      check($sformatf("vec%0d.tbl_data", i),  32'(bus.rd_data),   32'(vecs[i].e_data));
      check($sformatf("vec%0d.tbl_empty", i), 32'(bus.empty),     32'(vecs[i].e_count == 0));
      check($sformatf("vec%0d.tbl_uf", i),    32'(bus.underflow), 32'(vecs[i].e_uf));
    end

    // Fill, refused push while full, then pop-from-full with the push still held.
    step(1'b0, 8'h00, 1'b1, 1'b0, "drain0");
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
    check("full.full",  32'(bus.full),       32'd1);
    check("full.ready", 32'(bus.uart_ready), 32'd0);
    check("full.count", 32'(bus.count),      32'd8);
    step(1'b1, 8'h09, 1'b0, 1'b0, "refused");
    check("refused.count", 32'(bus.count),   32'd8);
    check("refused.head",  32'(bus.rd_data), 32'h01);
    step(1'b1, 8'h09, 1'b1, 1'b0, "pop_from_full");
    check("pop_from_full.ready", 32'(bus.uart_ready), 32'd1);
    check("pop_from_full.count", 32'(bus.count),      32'd7);
    step(1'b1, 8'h09, 1'b0, 1'b0, "accept09");
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain_order%0d", i), 32'(bus.rd_data), 32'(8'h02 + 8'(i)));
      step(1'b0, 8'h00, 1'b1, 1'b0, "drain_full");
    end

    // Sustained simultaneous push and pop at count 4; 20 pops wrap the pointers twice.
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, "prefill4");
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0, "pushpop");
      check("pushpop.count4", 32'(bus.count), 32'd4);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain4");

    // Randomized traffic in alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 3000; i++) begin
      ph = ((i / 150) % 2) == 0;
      step(($urandom_range(0, 99) < (ph ? 80 : 25)),
           8'($urandom),
           ($urandom_range(0, 99) < (ph ? 25 : 80)),
           ($urandom_range(0, 99) < 10),
           "rand");
    end

    // Reset mid-stream with a push and a pop in flight.
    while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0, "pre_rst_drain");
    step(1'b0, 8'h00, 1'b1, 1'b0, "pre_rst_uf");
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, "pre_rst_fill");
    check("pre_rst.count", 32'(bus.count), 32'd5);
    bus.uart_valid = 1'b1;
    bus.uart_data  = 8'h3c;
    bus.rd_en      = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("reset_mid");
    @(posedge clk);
    #1;
    check_reset_values("reset_held");
    bus.uart_valid = 1'b0;
    bus.rd_en      = 1'b0;
    rst            = 1'b0;
    model_q.delete();
    model_uf = 1'b0;
    step(1'b1, 8'ha5, 1'b0, 1'b0, "post_rst");
    rd = bus.rd_data;
    check("post_rst.rd_data", 32'(rd),        32'ha5);
    check("post_rst.count",   32'(bus.count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the `UART` receiver's `DataOut`/`DataOutValid`/`DataOutReady` handshake and the `Riscv151` memory-mapped UART read path. It decouples serial arrival from CPU polling, so back-to-back bytes, such as the echo traffic driven on `FPGA_SERIAL_RX`, are not lost while the core is stalled on a cache miss. It is a first-word-fall-through FIFO that reports count, empty and full status, and has a sticky underflow flag for firmware debug.

## Interface
- `DEPTH`, 8: number of byte entries; must be a power of two and at least 2.
- `WIDTH`, 8: data width in bits.
- `clk`  in  1  CPU clock (`cpu_clk_g` domain).
- `rst`  in  1  asynchronous, active-high reset.
- `uart_data`  in  WIDTH  byte from the UART receiver (`DataOut`).
- `uart_valid`  in  1  receiver has a byte (`DataOutValid`).
- `uart_ready`  out  1  FIFO accepts a byte (`DataOutReady`).
- `rd_en`  in  1  CPU pop strobe, one byte per asserted cycle.
- `rd_data`  out  WIDTH  head-of-FIFO byte, valid while `empty`=0.
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds DEPTH bytes.
- `count`  out  log2(DEPTH)+1  number of bytes held, 0..DEPTH.
- `underflow`  out  1  sticky: a pop was attempted while the FIFO was empty.
- `clr_underflow`  in  1  synchronous clear of `underflow`.

## Operation
- Storage: DEPTH×WIDTH register array, plus `wr_ptr` and `rd_ptr`, each log2(DEPTH) bits wide.
  - Both pointers wrap modulo DEPTH through natural binary overflow.
  - `count` is kept as an explicit register; it is not derived from the pointers.
- Push:
  - Occurs when `uart_valid && uart_ready`.
  - Writes `uart_data` to `mem[wr_ptr]` and increments `wr_ptr`.
- Pop:
  - Occurs when `rd_en && !empty`.
  - Increments `rd_ptr`.
- `uart_ready` = `!full`, computed from registered state only.
  - A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- Count update:
  - Push only: `count`+1.
  - Pop only: `count`−1.
  - Push and pop together (possible only when not full and not empty): `count` unchanged, both pointers advance.
- Status flags: `empty` = (`count`==0); `full` = (`count`==DEPTH). Both are decoded from the registered `count`.
- `rd_data` = `mem[rd_ptr]` when `empty`=0, else `WIDTH'h0`. The output is combinational from registered state.
- Underflow:
  - `rd_en && empty` leaves the pointers and `count` unchanged and sets `underflow` at the next edge.
  - `clr_underflow` clears `underflow` at the next edge.
  - If `clr_underflow` and a new underflow event occur in the same cycle, set wins.
- Reset (asynchronous, immediate):
  - `wr_ptr`, `rd_ptr`, `count` and `underflow` go to 0.
  - Outputs become: `empty`=1, `full`=0, `uart_ready`=1, `rd_data`=0, `count`=0.
  - Array contents need not be cleared.
  - Reset during a push or pop discards that operation and all stored bytes.

## Timing
- A byte pushed at edge N appears on `rd_data` and clears `empty` after edge N (1-cycle latency from accept to visible).
- A pop at edge N shows the next byte, or sets `empty`, after edge N.
- `uart_ready` deasserts in the cycle after the push that fills the FIFO.
  - It reasserts in the cycle after the first pop from full.
- All outputs change only on `clk` rising edges, apart from the asynchronous assertion of reset.
- No combinational path from `uart_valid` to `uart_ready`, or from `rd_en` to any output.

## Test plan
- Reset with no traffic:
  - Assert `rst` mid-cycle -> `empty`=1, `full`=0, `uart_ready`=1, `count`=0, `rd_data`=8'h00, `underflow`=0, all without waiting for a clock edge.
- Ordering:
  - Push 8'h7a, 8'h80, 8'h55 on consecutive cycles -> `count`=3, and `rd_data`=8'h7a the cycle after the first push.
  - Three pops -> `rd_data` sequence 8'h7a, 8'h80, 8'h55, then `empty`=1 and `rd_data`=8'h00.
- Full and refused push:
  - Push 8 bytes 8'h01..8'h08 -> `full`=1, `uart_ready`=0, `count`=8.
  - Hold `uart_valid` with 8'h09 -> not accepted.
  - One pop -> `uart_ready`=1 the next cycle, 8'h09 is accepted, and the drained order is 8'h02..8'h09.
- Simultaneous push and pop:
  - At `count`=4, push and pop every cycle for 20 cycles -> `count` stays 4, data is in order, and both pointers wrap at least twice.
- Underflow:
  - With `empty`=1, pulse `rd_en` -> `underflow`=1 and `count` stays 0.
  - Assert `clr_underflow` and `rd_en` together while empty -> `underflow` stays 1.
  - `clr_underflow` alone -> `underflow`=0.
- Reset mid-stream:
  - With `count`=5, assert `rst` while `uart_valid`=1 and `rd_en`=1 -> all outputs immediately return to their reset values.
  - After release, push 8'hA5 -> `rd_data`=8'hA5 and `count`=1.
